pc_generator: RTL
=================

# pc_generator

Program Counter Generator: the front-end stage that consumes branch/jump redirects from the instruction committer (`wbpcg` stream) and produces the sequential fetch-address stream for instruction fetch. It holds the architectural fetch PC, advances it by 4 on each accepted fetch request, and retargets it on a committed taken branch. Each retarget also bumps an epoch tag and pulses a flush, so downstream stages can discard wrong-path work.

## Interface
Parameters:
- `XLEN`, 32, address width.
- `RESET_VECTOR`, `32'h8000_0000`, first fetch PC after reset.
- `EPOCH_W`, 2, epoch tag width.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = in reset); release synchronous to `clk` is guaranteed upstream.
- `wbpcg_axis_if`  slave  XLEN  redirect stream from committer; `tdata` = new PC.
- `pcgif_axis_if`  master  `pcgif_tdata_t`  fetch request stream; `tdata` = {`pc`[XLEN], `epoch`[EPOCH_W]}.
- `flush`  out  1  one-cycle pulse; downstream front-end drops everything tagged with the old epoch.
- `misalign`  out  1  sticky flag: a redirect target with nonzero bits [1:0] was received.

## Operation
- Registers: `pc_q`, `epoch_q`, `state_q`, `misalign_q`.
- FSM states:
  - `BOOT`: reset state; `pcgif.tvalid` = 0; lasts exactly one cycle after reset release, then goes to `RUN`.
  - `RUN`: `pcgif.tvalid` = 1; `tdata` = {`pc_q`, `epoch_q`}.
  - `FLUSH`: `pcgif.tvalid` = 0; `flush` = 1; lasts one cycle, then goes to `RUN`.
- Reset values: `pc_q` = `RESET_VECTOR`, `epoch_q` = 0, `state_q` = `BOOT`, `misalign_q` = 0. All outputs are 0 during reset.
- `wbpcg.tready` = 1 in every state outside reset; a redirect is never back-pressured.
- Redirect (`wbpcg.tvalid` high) in any state:
  - `pc_q` ← `tdata`.
  - `epoch_q` ← `epoch_q` + 1, wrapping modulo 2^EPOCH_W.
  - `state_q` ← `FLUSH`.
- A redirect arriving in `FLUSH` loads the newer target, increments the epoch again, and holds `FLUSH` one more cycle.
- A redirect arriving in `BOOT` overrides `RESET_VECTOR` and goes to `FLUSH`.
- Fetch handshake (`RUN`, `tvalid` && `tready`): `pc_q` ← `pc_q` + 4, computed modulo 2^XLEN (`FFFF_FFFC` wraps to `0000_0000`).
- Simultaneous redirect and handshake: the handshake still completes (the old PC counts as issued under the old epoch), but the redirect sets `pc_q`; there is no +4.
- In `RUN` with `tready` = 0, `tdata` stays stable. The only way `tdata` changes while valid is through `FLUSH`, which drops `tvalid` first.

## Timing
- Reset release at edge N: `BOOT` during cycle N; the first fetch (`RESET_VECTOR`) is valid from cycle N+1.
- Redirect sampled at edge T:
  - `flush` = 1 and `tvalid` = 0 during cycle T+1.
  - New PC valid with the new epoch from cycle T+2.
  - Redirect-to-fetch latency is 2 cycles.
- Sustained throughput in `RUN` with `tready` = 1: one request per cycle.
- Reset asserted mid-operation: all state and outputs clear asynchronously; any in-flight redirect is lost.

## Configuration
- `OFFNARISCV_PCG_ALIGN_CHECK_EN` defined:
  - Redirect target bits [1:0] are forced to 0 before loading `pc_q`.
  - `misalign_q` is set to 1 if they were nonzero; it clears only on reset.
- Undefined:
  - The target loads unmodified.
  - `misalign` is tied to 0; the port remains present.

## Structure
- Shared package `offnariscv_pkg`:
  - `pcgif_tdata_t` (packed {`pc`, `epoch`}).
  - `pcg_state_e` {`BOOT`, `RUN`, `FLUSH`}.
  - Default `RESET_VECTOR` constant.
  - `wbpcg_tdata_t` (XLEN-bit new PC).
- No sub-module: the block is a single FSM plus PC/epoch registers.

## Test plan
- Reset release, `tready` = 1 for 4 cycles -> PCs `8000_0000`, `…04`, `…08`, `…0C`, all with epoch 0; `BOOT` gap of exactly 1 cycle.
- `tready` = 0 for 3 cycles in `RUN` -> `tdata` holds `8000_0004`, `tvalid` stays 1; the next accept outputs `…08`.
- Redirect to `8000_0100` at edge T -> `flush` high at T+1, `tvalid` low; at T+2 PC `8000_0100` with epoch 1.
- Redirect coincident with handshake of `8000_0008` -> that handshake counts; next PC is the target, not `…0C`.
- Back-to-back redirects `…0200` then `…0300` -> two `FLUSH` cycles; epoch advances 0→2; next PC `…0300`; four more redirects wrap epoch to 2.
- With `_EN`: redirect to `8000_0102` -> PC `8000_0100`, `misalign` = 1 and stays 1. Without `_EN`: PC `8000_0102`, `misalign` = 0.

Source files
------------

// File: rtl/offnariscv_pkg.sv
// Shared front-end types and constants for the program counter generator.
package offnariscv_pkg;

   localparam int                  PCG_XLEN         = 32;
   localparam int                  PCG_EPOCH_W      = 2;
   localparam logic [PCG_XLEN-1:0] PCG_RESET_VECTOR = 32'h8000_0000;

   typedef logic [PCG_XLEN-1:0] wbpcg_tdata_t;

   typedef struct packed {
      logic [PCG_XLEN-1:0]    pc;
      logic [PCG_EPOCH_W-1:0] epoch;
   } pcgif_tdata_t;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } pcg_state_e;

endpackage

// File: rtl/pc_generator_if.sv
// Minimal valid/ready stream carrying a W-bit payload.
interface pc_generator_if #(
   parameter int W = 32
) ();
   logic         tvalid;
   logic         tready;
   logic [W-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pc_generator.sv
// Fetch PC generator: sequential fetch stream, redirect retargeting with epoch/flush.
// Optional alignment check enabled by defining OFFNARISCV_PCG_ALIGN_CHECK_EN.
//
// state | meaning
// BOOT  | first cycle after reset release, no fetch issued
// RUN   | fetch request {pc_q, epoch_q} offered every cycle
// FLUSH | one bubble after a redirect, flush pulse to downstream
module pc_generator
   import offnariscv_pkg::*;
#(
   parameter int              XLEN         = PCG_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = PCG_RESET_VECTOR,
   parameter int              EPOCH_W      = PCG_EPOCH_W
) (
   input  logic                  clk,
   input  logic                  rst,
   pc_generator_if.slave         wbpcg_axis_if,
   pc_generator_if.master        pcgif_axis_if,
   output logic                  flush,
   output logic                  misalign
);

   pcg_state_e           state_q;
   logic [XLEN-1:0]      pc_q;
   logic [EPOCH_W-1:0]   epoch_q;
   logic                 valid_q;
   logic                 flush_q;
   logic [XLEN-1:0]      target;

`ifdef OFFNARISCV_PCG_ALIGN_CHECK_EN
   logic misalign_q;

   assign target   = {wbpcg_axis_if.tdata[XLEN-1:2], 2'b00};
   assign misalign = misalign_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_q <= 1'b0;
      end else if (wbpcg_axis_if.tvalid && (wbpcg_axis_if.tdata[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end
`else
   assign target   = wbpcg_axis_if.tdata;
   assign misalign = 1'b0;
`endif

   // Redirects are never back-pressured; ready only drops while reset is held.
   assign wbpcg_axis_if.tready = rst;
   assign pcgif_axis_if.tvalid = valid_q;
   assign pcgif_axis_if.tdata  = valid_q ? {pc_q, epoch_q} : '0;
   assign flush                = flush_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         epoch_q <= '0;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
      end else if (wbpcg_axis_if.tvalid) begin
         // A coincident fetch handshake still completes under the old epoch; no +4.
         state_q <= FLUSH;
         pc_q    <= target;
         epoch_q <= epoch_q + EPOCH_W'(1);
         valid_q <= 1'b0;
         flush_q <= 1'b1;
      end else begin
         case (state_q)
            BOOT, FLUSH: begin
               state_q <= RUN;
               valid_q <= 1'b1;
               flush_q <= 1'b0;
            end
            RUN: begin
               if (pcgif_axis_if.tready) begin
                  pc_q <= pc_q + XLEN'(4);
               end
            end
            default: begin
               state_q <= BOOT;
               valid_q <= 1'b0;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
